// File: rtl/dc_arbiter.sv
// Two-requester round-robin arbiter in front of a single data-cache port.
// Optional WAIT-state timeout with sticky io_err: define DC_ARB_TIMEOUT_EN.
module dc_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_m0_rd,
  input  logic              io_m0_wr,
  input  logic [ADDR_W-1:0] io_m0_address,
  input  logic [DATA_W-1:0] io_m0_data_in,
  output logic [DATA_W-1:0] io_m0_data_out,
  output logic              io_m0_ack,
  input  logic              io_m1_rd,
  input  logic              io_m1_wr,
  input  logic [ADDR_W-1:0] io_m1_address,
  input  logic [DATA_W-1:0] io_m1_data_in,
  output logic [DATA_W-1:0] io_m1_data_out,
  output logic              io_m1_ack,
  output logic              io_dc_rd,
  output logic              io_dc_wr,
  output logic [ADDR_W-1:0] io_dc_address,
  output logic [DATA_W-1:0] io_dc_data_in,
  input  logic [DATA_W-1:0] io_dc_data_out,
  input  logic              io_dc_stall,
  output logic              io_busy,
  output logic              io_err
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    EVAL,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic              req0, req1, any_req;
  logic              win, grant, last_grant;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              timeout_hit;
  logic              rd_load;
  logic [DATA_W-1:0] rd_val;

  assign req0    = io_m0_rd | io_m0_wr;
  assign req1    = io_m1_rd | io_m1_wr;
  assign any_req = req0 | req1;
  assign win     = (req0 & req1) ? ~last_grant : req1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = EVAL;
      EVAL:    state_nxt = WAIT;
      WAIT:    if (!io_dc_stall || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io_dc_rd      = 1'b0;
    io_dc_wr      = 1'b0;
    io_dc_address = '0;
    io_dc_data_in = '0;
    if (state == ISSUE) begin
      io_dc_rd      = ~lat_wr;
      io_dc_wr      = lat_wr;
      io_dc_address = lat_addr;
      io_dc_data_in = lat_data;
    end
  end

  assign io_busy   = (state != IDLE);
  assign io_m0_ack = (state == DONE) & ~grant;
  assign io_m1_ack = (state == DONE) & grant;

  // A timed-out read returns zero instead of whatever the cache drives.
  assign rd_load = (state == WAIT) & ~lat_wr & (~io_dc_stall | timeout_hit);
  assign rd_val  = io_dc_stall ? '0 : io_dc_data_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      lat_wr         <= 1'b0;
      lat_addr       <= '0;
      lat_data       <= '0;
      io_m0_data_out <= '0;
      io_m1_data_out <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant      <= win;
        last_grant <= win;
        lat_wr     <= win ? io_m1_wr : io_m0_wr;
        lat_addr   <= win ? io_m1_address : io_m0_address;
        lat_data   <= win ? io_m1_data_in : io_m0_data_in;
      end
      if (rd_load) begin
        if (grant) io_m1_data_out <= rd_val;
        else       io_m0_data_out <= rd_val;
      end
    end
  end

`ifdef DC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout_hit = io_dc_stall & (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign io_err      = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (state == WAIT && timeout_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
  assign io_err         = 1'b0;
`endif

endmodule
